// File: rtl/test_monitor.sv
// test_monitor: simulation-style test supervisor built as synthesizable logic.
// It holds the DUT in reset for RESET_CYCLES cycles and then runs the test.
// It ends in PASS when every enabled channel has reported success.
// It ends in FAIL on a channel failure, a progress stall or a cycle timeout.
// Optional feature: define TEST_MONITOR_STALL_DETECT_EN to build the
// progress-stall detector. Without it, the progress input is ignored.
module test_monitor #(
    parameter int NUM_CH       = 4,
    parameter int CNT_W        = 64,
    parameter int RESET_CYCLES = 16,
    parameter int STALL_LIMIT  = 1024,
    localparam int FCH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [CNT_W-1:0]  max_cycles,
    input  logic [NUM_CH-1:0] ch_enable,
    input  logic [NUM_CH-1:0] ch_success,
    input  logic [NUM_CH-1:0] ch_failure,
    input  logic              progress,
    output logic              dut_reset,
    output logic              done,
    output logic              pass,
    output logic              fail,
    output logic [1:0]        reason,
    output logic [FCH_W-1:0]  fail_ch,
    output logic              finish,
    output logic [CNT_W-1:0]  cycle_count
);

    localparam int HOLD_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

    typedef enum logic [1:0] {HOLD, RUN, PASS, FAIL} state_e;
    typedef enum logic [1:0] {RSN_NONE, RSN_CHANNEL, RSN_STALL, RSN_TIMEOUT} reason_e;

    state_e             state_q, state_d;
    logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
    logic [CNT_W-1:0]   cycle_cnt_q, cycle_cnt_d;
    logic [NUM_CH-1:0]  succ_q, succ_d;
    logic               done_q, done_d;
    logic               pass_q, pass_d;
    logic               fail_q, fail_d;
    logic               finish_q, finish_d;
    reason_e            reason_q, reason_d;
    logic [FCH_W-1:0]   fail_ch_q, fail_ch_d;

    logic               stall_hit;
    logic [NUM_CH-1:0]  fail_vec;
    logic [FCH_W-1:0]   first_fail;
    logic               all_ok;
    logic               timeout_hit;

`ifdef TEST_MONITOR_STALL_DETECT_EN
    localparam int STALL_W = $clog2(STALL_LIMIT + 1);

    logic               progress_q;
    logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;
    logic               progress_edge;

    // Stall counter: clears on any progress change, counts otherwise in RUN.
    always_comb begin
        progress_edge = progress ^ progress_q;
        stall_cnt_d   = stall_cnt_q;
        stall_hit     = 1'b0;
        if (state_q == RUN) begin
            if (progress_edge) begin
                stall_cnt_d = '0;
            end else begin
                stall_cnt_d = stall_cnt_q + 1'b1;
                stall_hit   = (stall_cnt_q == STALL_W'(STALL_LIMIT - 1));
            end
        end
    end

    // Progress history and stall counter registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            progress_q  <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            progress_q  <= progress;
            stall_cnt_q <= stall_cnt_d;
        end
    end
`else
    logic unused_progress;

    // Without the detector the heartbeat is intentionally left unobserved.
    always_comb begin
        unused_progress = progress;
        stall_hit       = 1'b0;
    end
`endif

    // Per-cycle event decode: lowest failing channel, pass condition, timeout.
    always_comb begin
        fail_vec   = ch_failure & ch_enable;
        first_fail = '0;
        // Walk from the top so the lowest set index is the last one written.
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (fail_vec[i]) first_fail = FCH_W'(i);
        end
        // This cycle's success counts as already latched; disabled channels are satisfied.
        all_ok      = &(succ_q | (ch_success & ch_enable) | ~ch_enable);
        timeout_hit = (max_cycles != '0) && (cycle_cnt_q == max_cycles - 1'b1);
    end

    // Next-state and flag logic for the HOLD/RUN/PASS/FAIL sequence.
    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        state_d     = state_q;
        hold_cnt_d  = hold_cnt_q;
        cycle_cnt_d = cycle_cnt_q;
        succ_d      = succ_q;
        done_d      = done_q;
        pass_d      = pass_q;
        fail_d      = fail_q;
        finish_d    = 1'b0;
        reason_d    = reason_q;
        fail_ch_d   = fail_ch_q;

        unique case (state_q)
            HOLD: begin
                if (hold_cnt_q == HOLD_W'(RESET_CYCLES - 1)) state_d = RUN;
                else                                          hold_cnt_d = hold_cnt_q + 1'b1;
            end
            RUN: begin
                if (cycle_cnt_q != '1) cycle_cnt_d = cycle_cnt_q + 1'b1;
                succ_d = succ_q | (ch_success & ch_enable);
                // Priority: channel failure, stall, timeout, pass.
                if (|fail_vec) begin
                    state_d   = FAIL;
                    reason_d  = RSN_CHANNEL;
                    fail_ch_d = first_fail;
                end else if (stall_hit) begin
                    state_d  = FAIL;
                    reason_d = RSN_STALL;
                end else if (timeout_hit) begin
                    state_d  = FAIL;
                    reason_d = RSN_TIMEOUT;
                end else if (all_ok) begin
                    state_d = PASS;
                end
                if (state_d == FAIL) begin
                    done_d   = 1'b1;
                    fail_d   = 1'b1;
                    finish_d = 1'b1;
                end else if (state_d == PASS) begin
                    done_d   = 1'b1;
                    pass_d   = 1'b1;
                    finish_d = 1'b1;
                end
            end
            default: ; // PASS and FAIL are terminal; everything holds.
        endcase
    end

    // State and flag registers with synchronous reset back to the start of HOLD.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (reset) begin
            state_q     <= HOLD;
            hold_cnt_q  <= '0;
            cycle_cnt_q <= '0;
            succ_q      <= '0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_q      <= 1'b0;
            finish_q    <= 1'b0;
            reason_q    <= RSN_NONE;
            fail_ch_q   <= '0;
        end else begin
            state_q     <= state_d;
            hold_cnt_q  <= hold_cnt_d;
            cycle_cnt_q <= cycle_cnt_d;
            succ_q      <= succ_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            fail_q      <= fail_d;
            finish_q    <= finish_d;
            reason_q    <= reason_d;
            fail_ch_q   <= fail_ch_d;
        end
    end

    assign dut_reset   = (state_q == HOLD);
    assign done        = done_q;
    assign pass        = pass_q;
    assign fail        = fail_q;
    assign finish      = finish_q;
    assign reason      = reason_q;
    assign fail_ch     = fail_ch_q;
    assign cycle_count = cycle_cnt_q;

endmodule

// File: tb/tb_test_monitor.sv
// Testbench for test_monitor: directed scenarios with a finish-driven scoreboard.
// Each scenario pushes its expected terminal result. A monitor pops and
// compares an entry whenever finish pulses.
module tb_test_monitor;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 64;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic [CNT_W-1:0]  max_cycles = '0;
    logic [NUM_CH-1:0] ch_enable  = '0;
    logic [NUM_CH-1:0] ch_success = '0;
    logic [NUM_CH-1:0] ch_failure = '0;
    logic              progress   = 1'b0;
    logic              dut_reset, done, pass, fail, finish;
    logic [1:0]        reason;
    logic [1:0]        fail_ch;
    logic [CNT_W-1:0]  cycle_count;

    test_monitor #(
        .NUM_CH(NUM_CH), .CNT_W(CNT_W), .RESET_CYCLES(16), .STALL_LIMIT(8)
    ) dut (
        .clock(clock), .reset(reset), .max_cycles(max_cycles),
        .ch_enable(ch_enable), .ch_success(ch_success), .ch_failure(ch_failure),
        .progress(progress), .dut_reset(dut_reset), .done(done), .pass(pass),
        .fail(fail), .reason(reason), .fail_ch(fail_ch), .finish(finish),
        .cycle_count(cycle_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        pass;
        logic        fail;
        logic [1:0]  reason;
        logic [1:0]  fail_ch;
        logic [63:0] count;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cur    = 0;   // cycle index since reset release
    logic prog_toggle = 1'b1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic p, input logic f, input logic [1:0] r,
                        input logic [1:0] ch, input logic [63:0] cnt);
        exp_t e;
        e.pass = p; e.fail = f; e.reason = r; e.fail_ch = ch; e.count = cnt;
        sb.push_back(e);
    endtask

    task automatic adv(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
            cur++;
        end
    endtask

    task automatic at_cycle(input int c);
        if (c > cur) adv(c - cur);
    endtask

    // Assert reset, verify the cleared state, then release so cycle 0 begins.
    task automatic apply_reset();
        reset = 1'b1;
        ch_success = '0;
        ch_failure = '0;
        repeat (2) begin
            @(posedge clock);
            #1;
        end
        @(negedge clock);
        check("rst_dut_reset", dut_reset, 1);
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_fail", fail, 0);
        check("rst_finish", finish, 0);
        check("rst_reason", reason, 0);
        check("rst_fail_ch", fail_ch, 0);
        check("rst_cycle_count", cycle_count, 0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        cur = 0;
    endtask

    // dut_reset high for cycles 0..15, low from cycle 16.
    task automatic hold_sequence_check();
        for (int c = 0; c <= 16; c++) begin
            at_cycle(c);
            @(negedge clock);
            check($sformatf("hold_dut_reset_c%0d", c), dut_reset, (c < 16) ? 1 : 0);
        end
        check("hold_cycle_count", cycle_count, 0);
    endtask

    // Heartbeat generator: toggles progress every cycle while enabled.
    initial forever begin
        @(posedge clock);
        #1;
        if (prog_toggle) progress = ~progress;
    end

    // Scoreboard monitor: compare on every finish pulse, and check it lasts one cycle.
    logic prev_finish = 1'b0;
    always @(negedge clock) begin
        if (prev_finish) check("finish_one_cycle", finish, 0);
        prev_finish = finish;
        if (finish) begin
            if (sb.size() == 0) begin
                check("unexpected_finish", finish, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sb_done", done, 1);
                check("sb_pass", pass, e.pass);
                check("sb_fail", fail, e.fail);
                check("sb_reason", reason, e.reason);
                check("sb_fail_ch", fail_ch, e.fail_ch);
                check("sb_cycle_count", cycle_count, e.count);
            end
        end
    end

    initial begin
        // A: hold timing, then pass with two enabled channels (0101).
        ch_enable  = 4'b0101;
        max_cycles = '0;
        apply_reset();
        hold_sequence_check();
        push(1'b1, 1'b0, 2'd0, 2'd0, 64'd31);
        at_cycle(26); ch_success = 4'b0001;
        at_cycle(27); ch_success = 4'b0000;
        at_cycle(46); ch_success = 4'b0100;
        at_cycle(47); ch_success = 4'b0000;
        // Terminal PASS ignores later failures and freezes cycle_count.
        at_cycle(48); ch_failure = 4'b1111;
        at_cycle(50);
        @(negedge clock);
        check("pass_sticky", pass, 1);
        check("pass_no_fail", fail, 0);
        check("pass_count_held", cycle_count, 31);
        check("pass_sb_empty", sb.size(), 0);
        at_cycle(51); ch_failure = 4'b0000;

        // Reset 5 cycles after PASS: full HOLD sequence repeats.
        at_cycle(52);
        apply_reset();
        hold_sequence_check();

        // B: channel failures 1 and 3 coincide with timeout and all successes.
        ch_enable  = 4'b1111;
        max_cycles = 64'd20;
        apply_reset();
        push(1'b0, 1'b1, 2'd1, 2'd1, 64'd20);
        at_cycle(35); ch_failure = 4'b1010; ch_success = 4'b1111;
        at_cycle(36); ch_failure = 4'b0000; ch_success = 4'b0000;
        at_cycle(40);
        check("b_sb_empty", sb.size(), 0);

        // C: inputs ignored in HOLD, disabled-channel failure ignored, then channel 2 fails.
        ch_enable  = 4'b0101;
        max_cycles = '0;
        apply_reset();
        push(1'b0, 1'b1, 2'd1, 2'd2, 64'd25);
        at_cycle(2);  ch_failure = 4'b1111; ch_success = 4'b1111;
        at_cycle(10); ch_failure = 4'b0000; ch_success = 4'b0000;
        at_cycle(20); ch_failure = 4'b1010;
        at_cycle(23); ch_failure = 4'b0000;
        @(negedge clock);
        check("c_no_early_done", done, 0);
        at_cycle(40); ch_failure = 4'b0100;
        at_cycle(41); ch_failure = 4'b0000;
        at_cycle(44);
        check("c_sb_empty", sb.size(), 0);

        // D: timeout after exactly 100 RUN cycles.
        ch_enable  = 4'b0001;
        max_cycles = 64'd100;
        apply_reset();
        push(1'b0, 1'b1, 2'd3, 2'd0, 64'd100);
        at_cycle(16 + 105);
        check("d_sb_empty", sb.size(), 0);

        // E: no enabled channels passes on the first RUN cycle.
        ch_enable  = 4'b0000;
        max_cycles = '0;
        apply_reset();
        push(1'b1, 1'b0, 2'd0, 2'd0, 64'd1);
        at_cycle(20);
        check("e_sb_empty", sb.size(), 0);

        // E2: max_cycles=1 timeout outranks the immediate pass.
        max_cycles = 64'd1;
        apply_reset();
        push(1'b0, 1'b1, 2'd3, 2'd0, 64'd1);
        at_cycle(20);
        check("e2_sb_empty", sb.size(), 0);

`ifdef TEST_MONITOR_STALL_DETECT_EN
        // F1: progress held constant trips the stall detector after 8 RUN cycles.
        ch_enable   = 4'b0001;
        max_cycles  = '0;
        prog_toggle = 1'b0;
        apply_reset();
        push(1'b0, 1'b1, 2'd2, 2'd0, 64'd8);
        at_cycle(30);
        check("f1_sb_empty", sb.size(), 0);
        prog_toggle = 1'b1;
`else
        prog_toggle = 1'b0;
`endif

        // F2: max_cycles=0 never times out (and without the detector a flat heartbeat is fine).
        ch_enable  = 4'b0001;
        max_cycles = '0;
        apply_reset();
        at_cycle(16 + 10000);
        @(negedge clock);
        check("f2_no_done", done, 0);
        check("f2_no_fail", fail, 0);
        check("f2_count", cycle_count, 10000);
        check("f2_dut_reset", dut_reset, 0);

        check("final_sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
